mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the processor's instruction-fetch and load/store request interfaces. It accepts fetch, `ld` and `st` requests and drives the `wait_instr`/`wait_data` stall signals and the `instr_segv`/`data_segv` fault flags. It arbitrates both request streams onto one single-port synchronous RAM with a fixed read latency and returns fetched instructions and load data in registers.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM word-address width; valid byte addresses are `0 .. 4*2^ADDR_W-1`.
- `LATENCY`, default 2: number of cycles from the `ram_re` cycle until `ram_rdata` is valid. Legal range is 1..7.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch`  in  1  instruction-fetch request; held high until the done cycle.
- `pc`  in  32  fetch byte address; held stable while `fetch` is high.
- `instruction`  out  32  registered fetched word.
- `wait_instr`  out  1  fetch pending and not yet done.
- `instr_segv`  out  1  fetch fault; one-cycle pulse in the done cycle.
- `ld`, `st`  in  1  load and store requests; held high until the done cycle.
- `data_addr`  in  32  data byte address; held stable while `ld` or `st` is high.
- `st_data`  in  32  store data.
- `ld_data`  out  32  registered load result.
- `wait_data`  out  1  data request pending and not yet done.
- `data_segv`  out  1  data fault; one-cycle pulse in the done cycle.
- `ram_addr`  out  ADDR_W  RAM word address, `addr[ADDR_W+1:2]`.
- `ram_wdata`  out  32  RAM write data.
- `ram_we`, `ram_re`  out  1  RAM write and read strobes.
- `ram_rdata`  in  32  RAM read data.

## Operation
- States: IDLE, DREAD, IREAD, DDONE, IDONE, DFAULT, IFAULT.
- Arbitration in IDLE:
  - A data request (`ld|st`) has priority over `fetch`.
  - A fetch is serviced only when no data request is present.
- Fault check is performed in IDLE on the selected request. A fault is any of:
  - `addr[31:ADDR_W+2] != 0`;
  - `ld & st` both high (data port only);
  - alignment fault (see Configuration).
- A faulting request goes to DFAULT or IFAULT. No RAM strobe is issued.
- Load or fetch from IDLE:
  - Assert `ram_re` with `ram_addr` for one cycle.
  - Go to DREAD or IREAD, which counts `LATENCY` cycles with a 3-bit counter.
  - On the final count, capture `ram_rdata` into `ld_data` or `instruction`.
  - Go to DDONE or IDONE.
- Store from IDLE: assert `ram_we`, `ram_addr` and `ram_wdata=st_data` for one cycle, then go straight to DDONE.
- Done and fault states last exactly one cycle, then return to IDLE.
- `wait_data = (ld|st) & ~(state==DDONE | state==DFAULT)`. `wait_instr` is the same with IDONE/IFAULT. Both outputs are combinational.
- `data_segv` is high only in DFAULT; `instr_segv` is high only in IFAULT.
- A requester must drop or replace its request in the cycle after its done cycle. A request still high in IDLE is treated as a new request.
- `ld_data` and `instruction` hold their value until the next successful load or fetch completes. A faulting request leaves them unchanged.
- Reset values:
  - state IDLE, counter 0;
  - `ld_data` and `instruction` 0;
  - all strobes and `segv` outputs 0;
  - `wait_*` follow the request inputs.
- Reset mid-access abandons the access. A store is either fully written (its `ram_we` cycle has passed) or not written at all.

## Timing
- Load or fetch: request sampled in cycle 0 with `ram_re` high. Done in cycle `LATENCY+1`; the result is readable in that cycle, so `wait_*` is high for `LATENCY+1` cycles.
- Store: `ram_we` in cycle 0, done in cycle 1, so `wait_data` is high for 1 cycle.
- Fault: done in cycle 1, with `segv` high in that cycle.
- A fetch blocked by a data access starts in the first IDLE cycle after the data done cycle, if no new data request is present.
- Back-to-back requests: a new request asserted in the cycle after done is sampled in that cycle. No idle bubble is required beyond the done cycle.

## Configuration
- `MEM_RESPONDER_ALIGN_CHECK_EN`:
  - Defined: `addr[1:0] != 0` on either port is a fault, giving `segv` and no RAM access.
  - Undefined: `addr[1:0]` is ignored and the access proceeds at `addr[ADDR_W+1:2]`.

## Test plan
- Store then load, `LATENCY=2`:
  - `st` to `data_addr=0x10` with `st_data=0xDEADBEEF` → `ram_we` in cycle 0, `wait_data` high for 1 cycle.
  - `ld` from 0x10 → `ld_data=0xDEADBEEF` in cycle 3, `wait_data` high for cycles 0–2.
- Simultaneous `fetch`(`pc=0x0`) and `ld`(0x10) in the same cycle → load done at cycle 3, then fetch sampled at cycle 4 and done at cycle 7. `wait_instr` is high for cycles 0–6.
- Out of range: `ld` at `0x0000_1000` with `ADDR_W=10` → `data_segv` pulse in cycle 1, no `ram_re`, `ld_data` unchanged.
- `ld & st` both high → `data_segv` in cycle 1, no `ram_we`.
- `ld` at 0x12:
  - With `MEM_RESPONDER_ALIGN_CHECK_EN` defined → `data_segv`.
  - Without it → load of word 4.
- `reset_n` low during DREAD cycle 1 → state returns to IDLE immediately and `ld_data=0`. After release, re-asserting `ld` completes normally in `LATENCY+1` cycles.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates fetch and load/store requests onto one synchronous RAM.
// Optional alignment fault checking is enabled by defining MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch,
    input  logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              wait_instr,
    output logic              instr_segv,
    input  logic              ld,
    input  logic              st,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       st_data,
    output logic [31:0]       ld_data,
    output logic              wait_data,
    output logic              data_segv,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StDRead,
        StIRead,
        StDDone,
        StIDone,
        StDFault,
        StIFault
    } state_e;

    // LATENCY must lie in 1..7 so the final count fits the 3-bit counter.
    localparam logic [2:0] LastCnt = 3'(LATENCY);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [31:0] instr_q, instr_d;
    logic        d_req, d_fault, i_fault;
    logic        d_misalign, i_misalign;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign d_misalign = (data_addr[1:0] != 2'b00);
    assign i_misalign = (pc[1:0] != 2'b00);
`else
    assign d_misalign = 1'b0;
    assign i_misalign = 1'b0;
`endif

    assign d_req   = ld | st;
    assign d_fault = ((data_addr >> (ADDR_W + 2)) != 32'd0) | (ld & st) | d_misalign;
    assign i_fault = ((pc >> (ADDR_W + 2)) != 32'd0) | i_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            ld_data_q <= 32'd0;
            instr_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            instr_q   <= instr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        instr_d   = instr_q;
        ram_addr  = '0;
        ram_wdata = 32'd0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            StIdle: begin
                if (d_req) begin
                    if (d_fault) begin
                        state_d = StDFault;
                    end else begin
                        ram_addr = data_addr[ADDR_W+1:2];
                        if (st) begin
                            ram_we    = 1'b1;
                            ram_wdata = st_data;
                            state_d   = StDDone;
                        end else begin
                            ram_re  = 1'b1;
                            cnt_d   = 3'd1;
                            state_d = StDRead;
                        end
                    end
                end else if (fetch) begin
                    if (i_fault) begin
                        state_d = StIFault;
                    end else begin
                        ram_addr = pc[ADDR_W+1:2];
                        ram_re   = 1'b1;
                        cnt_d    = 3'd1;
                        state_d  = StIRead;
                    end
                end
            end
            StDRead: begin
                if (cnt_q == LastCnt) begin
                    ld_data_d = ram_rdata;
                    cnt_d     = 3'd0;
                    state_d   = StDDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StIRead: begin
                if (cnt_q == LastCnt) begin
                    instr_d = ram_rdata;
                    cnt_d   = 3'd0;
                    state_d = StIDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                cnt_d   = 3'd0;
                state_d = StIdle;
            end
        endcase
        // No strobe may escape while reset is asserted, even with a request present.
        if (!reset_n) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    assign wait_data   = d_req & ~((state_q == StDDone) | (state_q == StDFault));
    assign wait_instr  = fetch & ~((state_q == StIDone) | (state_q == StIFault));
    assign data_segv   = (state_q == StDFault);
    assign instr_segv  = (state_q == StIFault);
    assign ld_data     = ld_data_q;
    assign instruction = instr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with a behavioural RAM of fixed read latency.
module tb_mem_responder;

    localparam int LATENCY = 2;
    localparam int ADDR_W  = 10;

    logic              clk;
    logic              reset_n;
    logic              fetch;
    logic [31:0]       pc;
    logic [31:0]       instruction;
    logic              wait_instr;
    logic              instr_segv;
    logic              ld;
    logic              st;
    logic [31:0]       data_addr;
    logic [31:0]       st_data;
    logic [31:0]       ld_data;
    logic              wait_data;
    logic              data_segv;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;

    int tests = 0;
    int fails = 0;

    mem_responder #(
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch      (fetch),
        .pc         (pc),
        .instruction(instruction),
        .wait_instr (wait_instr),
        .instr_segv (instr_segv),
        .ld         (ld),
        .st         (st),
        .data_addr  (data_addr),
        .st_data    (st_data),
        .ld_data    (ld_data),
        .wait_data  (wait_data),
        .data_segv  (data_segv),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word i preloads to 0xA5A5_0000 | i; read data is poisoned unless valid.
    logic [31:0]        mem [0:(1<<ADDR_W)-1];
    logic [31:0]        pipe [LATENCY];
    logic [LATENCY-1:0] pv;
    logic               mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'hA5A5_0000 | i;
            mem_init_done <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        pipe[0] <= mem[ram_addr];
        pv[0]   <= ram_re;
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
            pv[i]   <= pv[i-1];
        end
    end

    assign ram_rdata = pv[LATENCY-1] ? pipe[LATENCY-1] : 32'hBAD0_BAD0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one data request, counts cycles with wait_data high, then drops it after done.
    task automatic data_req(input logic l, input logic s, input logic [31:0] a,
                            input logic [31:0] d, output int cycles, output logic re_seen,
                            output logic we_seen, output logic segv_done);
        ld = l; st = s; data_addr = a; st_data = d;
        cycles = 0; re_seen = 1'b0; we_seen = 1'b0; segv_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!wait_data) begin
                segv_done = data_segv;
                break;
            end
            cycles++;
            re_seen = re_seen | ram_re;
            we_seen = we_seen | ram_we;
            next_cycle();
        end
        next_cycle();
        ld = 1'b0; st = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ld = 1'b1; st = 1'b0; fetch = 1'b0; data_addr = 32'h10;
        #3;
        tests++;
        if (ld_data !== 32'd0 || instruction !== 32'd0) begin
            fails++; $display("FAIL reset_regs: ld_data=%h instr=%h required 0", ld_data, instruction);
        end
        tests++;
        if (ram_re !== 1'b0 || ram_we !== 1'b0 || data_segv !== 1'b0 || instr_segv !== 1'b0) begin
            fails++; $display("FAIL reset_strobes: re=%b we=%b required 0", ram_re, ram_we);
        end
        tests++;
        if (wait_data !== 1'b1 || wait_instr !== 1'b0) begin
            fails++; $display("FAIL reset_wait: wd=%b wi=%b required 1/0", wait_data, wait_instr);
        end
        ld = 1'b0;
        repeat (3) next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_store();
        st = 1'b1; data_addr = 32'h10; st_data = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 10'd4 ||
            ram_wdata !== 32'hDEAD_BEEF || wait_data !== 1'b1) begin
            fails++;
            $display("FAIL store_c0: we=%b re=%b addr=%h wdata=%h wait=%b required 1 0 004 deadbeef 1",
                     ram_we, ram_re, ram_addr, ram_wdata, wait_data);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (wait_data !== 1'b0 || ram_we !== 1'b0) begin
            fails++; $display("FAIL store_c1: wait=%b we=%b required 0 0", wait_data, ram_we);
        end
        next_cycle();
        st = 1'b0;
        tests++;
        if (mem[4] !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL store_mem: mem[4]=%h required deadbeef", mem[4]);
        end
    endtask

    task automatic test_load();
        int cyc; logic re, we, sg;
        data_req(1'b1, 1'b0, 32'h10, 32'h0, cyc, re, we, sg);
        tests++;
        if (cyc !== LATENCY + 1 || re !== 1'b1 || we !== 1'b0 || sg !== 1'b0) begin
            fails++; $display("FAIL load_timing: wait cycles=%0d re=%b we=%b segv=%b required 3 1 0 0",
                              cyc, re, we, sg);
        end
        tests++;
        if (ld_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL load_data: ld_data=%h required deadbeef", ld_data);
        end
    endtask

    task automatic test_arbitration();
        fetch = 1'b1; pc = 32'h0; ld = 1'b1; data_addr = 32'h10;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) ld = 1'b0;
            @(negedge clk);
            tests++;
            if (wait_data !== (c <= 2) || wait_instr !== (c <= 6) || ram_re !== (c == 0 || c == 4)) begin
                fails++; $display("FAIL arb_c%0d: wd=%b wi=%b re=%b required %b %b %b", c, wait_data,
                                  wait_instr, ram_re, c <= 2, c <= 6, c == 0 || c == 4);
            end
            if (c == 7) begin
                tests++;
                if (instruction !== 32'hA5A5_0000 || ld_data !== 32'hDEAD_BEEF) begin
                    fails++; $display("FAIL arb_data: instr=%h ld=%h required a5a50000 deadbeef",
                                      instruction, ld_data);
                end
            end
            next_cycle();
        end
        fetch = 1'b0;
    endtask

    task automatic test_data_faults();
        int cyc; logic re, we, sg;
        data_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, cyc, re, we, sg);
        tests++;
        if (cyc !== 1 || re !== 1'b0 || sg !== 1'b1 || ld_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL range_fault: cycles=%0d re=%b segv=%b ld=%h required 1 0 1 deadbeef",
                              cyc, re, sg, ld_data);
        end
        data_req(1'b1, 1'b1, 32'h10, 32'h1234_5678, cyc, re, we, sg);
        tests++;
        if (cyc !== 1 || we !== 1'b0 || re !== 1'b0 || sg !== 1'b1 || mem[4] !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL ldst_fault: cycles=%0d we=%b segv=%b mem4=%h required 1 0 1 deadbeef",
                              cyc, we, sg, mem[4]);
        end
    endtask

    task automatic test_fetch_fault();
        fetch = 1'b1; pc = 32'h0000_1000;
        @(negedge clk);
        tests++;
        if (wait_instr !== 1'b1 || ram_re !== 1'b0 || instr_segv !== 1'b0) begin
            fails++; $display("FAIL ifault_c0: wi=%b re=%b segv=%b required 1 0 0",
                              wait_instr, ram_re, instr_segv);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (wait_instr !== 1'b0 || instr_segv !== 1'b1 || instruction !== 32'hA5A5_0000) begin
            fails++; $display("FAIL ifault_c1: wi=%b segv=%b instr=%h required 0 1 a5a50000",
                              wait_instr, instr_segv, instruction);
        end
        next_cycle();
        fetch = 1'b0;
    endtask

    task automatic test_misaligned();
        int cyc; logic re, we, sg;
        data_req(1'b1, 1'b0, 32'h16, 32'h0, cyc, re, we, sg);
        tests++;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if (cyc !== 1 || re !== 1'b0 || sg !== 1'b1 || ld_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL misalign: cycles=%0d re=%b segv=%b ld=%h required 1 0 1 deadbeef",
                              cyc, re, sg, ld_data);
        end
`else
        if (cyc !== LATENCY + 1 || sg !== 1'b0 || ld_data !== 32'hA5A5_0005) begin
            fails++; $display("FAIL misalign: cycles=%0d segv=%b ld=%h required 3 0 a5a50005",
                              cyc, sg, ld_data);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc; logic re, we, sg;
        data_req(1'b0, 1'b1, 32'h20, 32'h0000_55AA, cyc, re, we, sg);
        tests++;
        if (cyc !== 1 || we !== 1'b1 || re !== 1'b0) begin
            fails++; $display("FAIL b2b_store: cycles=%0d we=%b re=%b required 1 1 0", cyc, we, re);
        end
        data_req(1'b1, 1'b0, 32'h20, 32'h0, cyc, re, we, sg);
        tests++;
        if (cyc !== LATENCY + 1 || ld_data !== 32'h0000_55AA) begin
            fails++; $display("FAIL b2b_load: cycles=%0d ld=%h required 3 000055aa", cyc, ld_data);
        end
    endtask

    task automatic test_reset_mid_read();
        int cyc; logic re, we, sg;
        ld = 1'b1; data_addr = 32'h14;
        @(negedge clk);
        tests++;
        if (ram_re !== 1'b1) begin
            fails++; $display("FAIL rst_mid_c0: re=%b required 1", ram_re);
        end
        next_cycle();
        reset_n = 1'b0;
        #1;
        tests++;
        if (ld_data !== 32'd0 || instruction !== 32'd0 || ram_re !== 1'b0 || wait_data !== 1'b1) begin
            fails++; $display("FAIL rst_mid: ld=%h instr=%h re=%b wd=%b required 0 0 0 1",
                              ld_data, instruction, ram_re, wait_data);
        end
        ld = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        data_req(1'b1, 1'b0, 32'h14, 32'h0, cyc, re, we, sg);
        tests++;
        if (cyc !== LATENCY + 1 || re !== 1'b1 || ld_data !== 32'hA5A5_0005) begin
            fails++; $display("FAIL rst_recover: cycles=%0d re=%b ld=%h required 3 1 a5a50005",
                              cyc, re, ld_data);
        end
    endtask

    initial begin
        reset_n = 1'b0; fetch = 1'b0; pc = 32'h0; ld = 1'b0; st = 1'b0;
        data_addr = 32'h0; st_data = 32'h0;
        test_reset();
        test_store();
        test_load();
        test_arbitration();
        test_data_faults();
        test_fetch_fault();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
